rv_mc_ctrl: RTL
===============

# rv_mc_ctrl

Multi-cycle sequencer for the RV32I integer core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and muxes. It also drives the ALU operation code, the branch decision and the memory request handshake. It sits between the instruction register / register file / ALU datapath and the single shared instruction-data memory port.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value requested on pc_init while rst is low.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, synchronous, active-low
- instr  in  32  instruction register contents (valid from DECODE onward)
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory accepts/completes the current request
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store)
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_unsigned  out  1  zero-extend load data
- ir_we  out  1  latch fetched word into instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  0 PC+4, 1 PC+imm (branch adder), 2 ALU result & ~1
- pc_init  out  32  RESET_PC
- alu_op  out  4  ALU operation
- alu_src_a  out  2  0 rs1, 1 PC, 2 zero
- alu_src_b  out  1  0 rs2, 1 immediate
- rf_we  out  1  register file write
- wb_sel  out  2  0 ALU, 1 load data, 2 PC+4
- busy  out  1  high in every state except FETCH
- illegal  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, mem_addr_sel=0, mem_size=2. On mem_ready: ir_we=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: classify instr[6:0] and go to EXEC. An unsupported opcode, or an invalid funct7/funct3 pair for OP/OP-IMM, counts as illegal.
- EXEC by class:
  - OP, OP-IMM: ALU computes, go to WB.
  - LUI: a=zero, b=imm, ADD, go to WB.
  - AUIPC: a=PC, b=imm, ADD, go to WB.
  - LOAD, STORE: ADD rs1+imm, go to MEM.
  - BRANCH: compare, then pc_we=1 with pc_sel=1 if taken, else 0. Go to FETCH.
  - JAL: a=PC. JALR: a=rs1. Both use b=imm, ADD, pc_sel=2, pc_we=1, rf_we=1, wb_sel=2. Go to FETCH.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - SRA/SRAI select on funct7[5]. SUB applies to OP only; funct7[5] on ADDI is part of the immediate.
- Branch decision uses alu_zero:
  - BEQ/BNE: SUB, taken on zero / !zero.
  - BLT/BGE: SLT, taken on !zero / zero.
  - BLTU/BGEU: SLTU, taken on !zero / zero.
  - funct3 010 and 011 are illegal.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE, mem_size/mem_unsigned from funct3.
  - Legal loads are LB, LH, LW, LBU, LHU. Legal stores are SB, SH, SW.
  - On mem_ready: a load goes to WB. A store asserts pc_we (PC+4) and goes to FETCH.
- WB: rf_we=1 with wb_sel=0 (load: 1), pc_we=1 with pc_sel=0, go to FETCH.
- rf_we is forced 0 whenever rd (instr[11:7]) == 0.
- While mem_req is high and mem_ready is low, all memory outputs hold stable.

## Timing
- Outputs are Moore-decoded from state and instr. Combinational exceptions: ir_we, and the MEM-state pc_we, qualify with mem_ready.
- While rst is low, every output is 0 except pc_init. State resets to FETCH, illegal resets to 0. The first mem_req appears in the cycle after rst goes high.
- Reset asserted mid-instruction aborts it at the next edge and suppresses any pending write.
- Instruction cycles with zero-wait memory:
  - BRANCH, JAL, JALR: 3.
  - OP, OP-IMM, LUI, AUIPC, STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds one.

## Configuration
- RV_MC_CTRL_ILLEGAL_TRAP_EN:
  - Defined: an illegal instruction sets illegal and enters TRAP. TRAP drives all outputs 0 and busy=1 until reset.
  - Undefined: an illegal instruction executes as a NOP. EXEC asserts pc_we with pc_sel=0 and returns to FETCH. illegal stays 0.

## Structure
- Package rv_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - alu_op codes;
  - pc_sel, wb_sel and alu_src encodings;
  - the state enum.
- One sub-module, rv_alu_dec: a combinational instr to {alu_op, legal} decoder used in DECODE/EXEC. The FSM stays in rv_mc_ctrl.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with mem_ready=1:
  - FETCH→DECODE→EXEC→WB in 4 cycles;
  - alu_op=0 in EXEC;
  - rf_we=1, wb_sel=0 in WB;
  - pc_we with pc_sel=0.
- LW x5,8(x1) with mem_ready low for 2 cycles in MEM: mem_req, mem_addr_sel=1 and mem_size=2 are held for 3 cycles. Then WB has wb_sel=1, for 7 cycles total.
- BNE x1,x2 with alu_zero=0: alu_op=1, pc_we=1, pc_sel=1 in cycle 3. Repeat with alu_zero=1: pc_sel=0.
- JALR x0,0(x1): pc_sel=2, pc_we=1, rf_we=0 (rd=0).
- Opcode 0x0000007F:
  - with the macro: illegal=1 and the FSM stays in TRAP for 20 cycles;
  - without it: PC+4 and illegal=0.
- Drop rst during the MEM state of SW: no pc_we/rf_we. After release, mem_req=1 with mem_addr_sel=0.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared encodings for the RV32I multi-cycle controller.
// Opcodes, ALU operation codes, datapath mux selects, FSM states
// and the funct3 to ALU operation helper.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic SRCB_RS2 = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Register/immediate arithmetic ops share one funct3 map; alt picks SUB/SRA.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// rv_alu_dec: combinational instruction decoder producing the ALU
// operation and a legality flag for the controller.
module rv_alu_dec
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  alu_op_o,
  output logic        legal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  // Classify the opcode and check funct fields; ADDI never becomes SUB.
  always_comb begin
    alu_op_o = ALU_ADD;
    legal_o  = 1'b0;
    case (opc)
      OPC_OP: begin
        alu_op_o = alu_from_f3(f3, f7[5]);
        legal_o  = (f7 == 7'b0000000) ||
                   ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        alu_op_o = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      legal_o = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal_o = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal_o = 1'b1;
      end
      OPC_LOAD:   legal_o = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  legal_o = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
      OPC_BRANCH: begin
        legal_o = (f3[2:1] != 2'b01);
        if (!f3[2])     alu_op_o = ALU_SUB;
        else if (!f3[1]) alu_op_o = ALU_SLT;
        else            alu_op_o = ALU_SLTU;
      end
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I.
// Outputs are decoded from state and instr; ir_we and the MEM pc_we
// are qualified by mem_ready. rst is synchronous, active-low, and
// forces every output except pc_init to 0 while low.
// Build option RV_MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions set the
// sticky illegal flag and park in TRAP; otherwise they execute as NOP.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_init,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        busy,
  output logic        illegal
);

  state_t     state_q;
  logic       illegal_q;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       rd_nz;
  logic [3:0] dec_op;
  logic       dec_legal;
  logic       is_load;
  logic       is_store;
  logic       br_taken;
  logic       unused_instr;

  assign opc          = instr[6:0];
  assign f3           = instr[14:12];
  assign rd_nz        = (instr[11:7] != 5'd0);
  assign is_load      = (opc == OPC_LOAD);
  assign is_store     = (opc == OPC_STORE);
  // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero.
  assign br_taken     = alu_zero ^ (f3[0] ^ f3[2]);
  assign unused_instr = ^instr[24:15];
  assign pc_init      = RESET_PC;

  rv_alu_dec u_alu_dec (
    .instr_i  (instr),
    .alu_op_o (dec_op),
    .legal_o  (dec_legal)
  );

  // Instruction sequencing FSM and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
`ifdef RV_MC_CTRL_ILLEGAL_TRAP_EN
          if (!dec_legal) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
`else
          state_q <= S_EXEC;
`endif
        end
        S_EXEC: begin
          if (!dec_legal)                       state_q <= S_FETCH;
          else if (is_load || is_store)         state_q <= S_MEM;
          else if ((opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR))
                                                state_q <= S_FETCH;
          else                                  state_q <= S_WB;
        end
        S_MEM:    if (mem_ready) state_q <= is_load ? S_WB : S_FETCH;
        S_WB:     state_q <= S_FETCH;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state and instr, all gated by reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_op       = ALU_ADD;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = SRCB_RS2;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    busy         = 1'b0;
    illegal      = 1'b0;
    if (rst) begin
      illegal = illegal_q;
      busy    = (state_q != S_FETCH);
      // ALU stays configured through MEM and WB so its result is stable.
      if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
        alu_op = dec_op;
        case (opc)
          OPC_LUI:            alu_src_a = SRCA_ZERO;
          OPC_AUIPC, OPC_JAL: alu_src_a = SRCA_PC;
          default:            alu_src_a = SRCA_RS1;
        endcase
        alu_src_b = ((opc == OPC_OP) || (opc == OPC_BRANCH)) ? SRCB_RS2 : SRCB_IMM;
      end
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_size = MEM_WORD;
          ir_we    = mem_ready;
        end
        S_EXEC: begin
          if (!dec_legal) begin
            pc_we = 1'b1;
          end else if (opc == OPC_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
          end else if ((opc == OPC_JAL) || (opc == OPC_JALR)) begin
            pc_we  = 1'b1;
            pc_sel = PC_ALU;
            rf_we  = rd_nz;
            wb_sel = WB_PC4;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          mem_size     = f3[1:0];
          mem_unsigned = f3[2];
          pc_we        = is_store && mem_ready;
        end
        S_WB: begin
          rf_we  = rd_nz;
          wb_sel = is_load ? WB_LOAD : WB_ALU;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
